ram_copy_engine: RTL

RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

---
 rtl/ram_copy_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : ram_copy_engine
// Brief    : Word-by-word RAM-to-RAM copy engine (read/write alternating).
//            Optional fill mode compiled in with macro RAM_COPY_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_copy_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_load,
    input  logic [DATA_WIDTH-1:0] mem_out
`ifdef RAM_COPY_FILL_EN
    ,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] pattern
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
`ifdef RAM_COPY_FILL_EN
        ,
        S_FILL  = 3'd4
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [ADDR_WIDTH:0]   w_idx_inc;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic [ADDR_WIDTH-1:0] w_dst_addr;
    logic                  w_more;
`ifdef RAM_COPY_FILL_EN
    logic                  r_fill;
    logic [DATA_WIDTH-1:0] r_pattern;
`endif

    // Index is one bit wider than the address so a full 2^ADDR_WIDTH count fits.
    assign w_idx_inc  = r_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_more     = (w_idx_inc < r_len);
    assign w_src_addr = r_src + r_idx[ADDR_WIDTH-1:0];
    assign w_dst_addr = r_dst + r_idx[ADDR_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_hold    <= '0;
`ifdef RAM_COPY_FILL_EN
            r_fill    <= 1'b0;
            r_pattern <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src     <= src;
                        r_dst     <= dst;
                        r_len     <= len;
                        r_idx     <= '0;
`ifdef RAM_COPY_FILL_EN
                        r_fill    <= fill;
                        r_pattern <= pattern;
`endif
                    end
                end
                S_READ:  r_hold <= mem_out;
                S_WRITE: r_idx  <= w_idx_inc;
`ifdef RAM_COPY_FILL_EN
                S_FILL:  r_idx  <= w_idx_inc;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        mem_address  = '0;
        mem_in       = '0;
        mem_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_next = S_DONE;
                    end else begin
`ifdef RAM_COPY_FILL_EN
                        w_state_next = fill ? S_FILL : S_READ;
`else
                        w_state_next = S_READ;
`endif
                    end
                end
            end
            S_READ: begin
                busy         = 1'b1;
                mem_address  = w_src_addr;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                mem_address  = w_dst_addr;
                mem_in       = r_hold;
                mem_load     = 1'b1;
                w_state_next = w_more ? S_READ : S_DONE;
            end
`ifdef RAM_COPY_FILL_EN
            S_FILL: begin
                busy         = 1'b1;
                mem_address  = w_dst_addr;
                mem_in       = r_pattern;
                mem_load     = 1'b1;
                w_state_next = w_more ? S_FILL : S_DONE;
            end
`endif
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
